// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg
// Shared definitions for the four-master PCI fair arbiter:
//   - arb_state_t : arbiter sequencing states (IDLE, GRANT, BUSY, TURN)
//   - N_REQ       : number of bus masters
//   - OWNER_W     : width of a master index
//   - ONE_HOT_LSB : one-hot seed used to build grant vectors
//   - one_hot()   : master index -> one-hot grant vector
package pci_arb_pkg;

  localparam int N_REQ   = 4;
  localparam int OWNER_W = 2;

  localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    TURN
  } arb_state_t;

  function automatic logic [N_REQ-1:0] one_hot(input logic [OWNER_W-1:0] idx);
    return ONE_HOT_LSB << idx;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// pci_rr_pick
// Combinational round-robin picker. The search starts at the master after
// ptr and wraps, so the master at ptr itself has the lowest priority.
// Ports:
//   req    in  [N_REQ-1:0]   request vector
//   ptr    in  [OWNER_W-1:0] last granted master
//   winner out [OWNER_W-1:0] selected master (meaningless when any = 0)
//   any    out               at least one request is pending
module pci_rr_pick
  import pci_arb_pkg::*;
(
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               any
);

  logic [OWNER_W-1:0] idx;

  // Walk from the farthest offset to the nearest so that the closest
  // requesting master after ptr overwrites any earlier candidate.
  // Offset N_REQ wraps back onto ptr itself.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    any    = |req;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = ptr + OWNER_W'(off);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/pci_fair_arbiter.sv
// pci_fair_arbiter
// Round-robin PCI arbiter for four masters. Tracks FRAME#/IRDY# so grants
// only move at legal points, withdraws unused grants after GNT_TO cycles,
// and preempts a long transaction after LAT_TIMER busy cycles when another
// master is waiting.
// Optional feature: define PCI_ARB_PARK_EN to park the bus on PARK_ID when
// no master requests, and to track a parked master's transaction.
// Ports:
//   clk        in           bus clock
//   reset_n    in           asynchronous active-low reset
//   req        in  [3:0]    per-master request
//   frame_n    in           PCI FRAME#
//   irdy_n     in           PCI IRDY#
//   gnt        out [3:0]    registered one-hot grant (may be all zero)
//   owner      out [1:0]    current or last granted master
//   owner_vld  out          owner's transaction in progress
//   timeout    out          one-cycle pulse when a grant expires unused
module pci_fair_arbiter
  import pci_arb_pkg::*;
#(
  parameter int GNT_TO    = 16,
  parameter int LAT_TIMER = 32,
  parameter int PARK_ID   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic               frame_n,
  input  logic               irdy_n,
  output logic [N_REQ-1:0]   gnt,
  output logic [OWNER_W-1:0] owner,
  output logic               owner_vld,
  output logic               timeout
);

`ifdef PCI_ARB_PARK_EN
  localparam logic PARK_EN = 1'b1;
`else
  localparam logic PARK_EN = 1'b0;
`endif

  localparam logic [7:0]         GNT_LAST  = 8'(GNT_TO - 1);
  localparam logic [7:0]         LAT_MAX   = 8'(LAT_TIMER);
  localparam logic [OWNER_W-1:0] PARK_IDX  = OWNER_W'(PARK_ID);
  // Pointer starts on the last master so master 0 wins first.
  localparam logic [OWNER_W-1:0] PTR_RESET = OWNER_W'(N_REQ - 1);

  arb_state_t         state;
  logic [7:0]         cnt;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] winner;
  logic               any_req;
  logic               bus_idle;
  logic               other_req;

  assign bus_idle  = frame_n & irdy_n;
  assign other_req = |(req & ~one_hot(owner));

  pci_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any_req)
  );

  // Arbitration sequencer. All outputs are registered here; cnt counts
  // unused grant cycles in GRANT and busy cycles in BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= '0;
      ptr       <= PTR_RESET;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req && bus_idle) begin
            gnt   <= one_hot(winner);
            owner <= winner;
            ptr   <= winner;
            state <= GRANT;
          end else if (PARK_EN && !frame_n) begin
            // Parked master started a transaction on its standing grant.
            gnt       <= one_hot(PARK_IDX);
            owner     <= PARK_IDX;
            ptr       <= PARK_IDX;
            owner_vld <= 1'b1;
            state     <= BUSY;
          end else if (PARK_EN && !any_req) begin
            gnt <= one_hot(PARK_IDX);
          end else begin
            gnt <= '0;
          end
        end

        GRANT: begin
          // FRAME# wins over both a dropped request and expiry.
          if (!frame_n) begin
            cnt       <= '0;
            owner_vld <= 1'b1;
            state     <= BUSY;
          end else if (!req[owner]) begin
            gnt   <= '0;
            state <= TURN;
          end else if (cnt == GNT_LAST) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state   <= TURN;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        BUSY: begin
          if (bus_idle) begin
            gnt       <= '0;
            owner_vld <= 1'b0;
            state     <= TURN;
          end else if (cnt != LAT_MAX) begin
            cnt <= cnt + 8'd1;
          end else if (other_req) begin
            // Latency timer expired: withdraw the grant, the owner
            // finishes its current transaction on its own.
            gnt <= '0;
          end
        end

        TURN: begin
          gnt       <= '0;
          owner_vld <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end

        default: begin
          gnt       <= '0;
          owner_vld <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_fair_arbiter.sv
// tb_pci_fair_arbiter
// Scoreboard bench for pci_fair_arbiter. Each transaction scenario computes
// the timeline of output changes it should cause (grant, busy start,
// preemption, turnaround, timeout) and queues them; a monitor on the
// falling edge pops one entry whenever gnt/owner/owner_vld/timeout change
// and compares values and cycle number. The scoreboarded scenarios target
// the default build; with PCI_ARB_PARK_EN the reset and parking checks run.
module tb_pci_fair_arbiter;

  localparam int GNT_TO    = 16;
  localparam int LAT_TIMER = 32;
  localparam int PARK_ID   = 3;

  localparam int M_NORMAL  = 0;
  localparam int M_DROP    = 1;
  localparam int M_TIMEOUT = 2;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       frame_n;
  logic       irdy_n;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       owner_vld;
  logic       timeout;

  pci_fair_arbiter #(
    .GNT_TO    (GNT_TO),
    .LAT_TIMER (LAT_TIMER),
    .PARK_ID   (PARK_ID)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .frame_n   (frame_n),
    .irdy_n    (irdy_n),
    .gnt       (gnt),
    .owner     (owner),
    .owner_vld (owner_vld),
    .timeout   (timeout)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       vld;
    logic       to;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       mon_e;
  int         tests   = 0;
  int         fails   = 0;
  int         cyc     = 0;
  int         ptr_m   = 3;
  bit         mon_en  = 1'b0;
  logic [3:0] prev_gnt   = '0;
  logic [1:0] prev_owner = '0;
  logic       prev_vld   = 1'b0;
  logic       prev_to    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used as the timestamp for every expected change.
  always @(posedge clk) cyc = cyc + 1;

  function automatic rec_t make_rec(input string name, input int c, input logic [3:0] g,
                                    input int o, input logic v, input logic t);
    rec_t r;
    r.name  = name;
    r.cyc   = c;
    r.gnt   = g;
    r.owner = 2'(o);
    r.vld   = v;
    r.to    = t;
    return r;
  endfunction

  // Round-robin rule: search from the master after the last winner, wrap.
  function automatic int rr_winner(input logic [3:0] mask, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (mask[(last + off) % 4]) return (last + off) % 4;
    end
    return -1;
  endfunction

  // Monitor: every visible output change must match the next queued entry.
  always @(negedge clk) begin
    if (mon_en && (gnt !== prev_gnt || owner !== prev_owner ||
                   owner_vld !== prev_vld || timeout !== prev_to)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_change cyc=%0d actual gnt=%b owner=%0d vld=%b to=%b, required no change",
                 cyc, gnt, owner, owner_vld, timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || gnt !== mon_e.gnt || owner !== mon_e.owner ||
            owner_vld !== mon_e.vld || timeout !== mon_e.to) begin
          fails++;
          $display("[TB] FAIL %s actual cyc=%0d gnt=%b owner=%0d vld=%b to=%b, required cyc=%0d gnt=%b owner=%0d vld=%b to=%b",
                   mon_e.name, cyc, gnt, owner, owner_vld, timeout,
                   mon_e.cyc, mon_e.gnt, mon_e.owner, mon_e.vld, mon_e.to);
        end
      end
    end
    prev_gnt   = gnt;
    prev_owner = owner;
    prev_vld   = owner_vld;
    prev_to    = timeout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One arbitration from an idle arbiter. Called just after a clock edge
  // with the arbiter in IDLE at the next edge; returns at the first point
  // where the arbiter is back in IDLE for the following edge.
  //   M_NORMAL : owner starts FRAME# so it is sampled k edges after grant,
  //              bus stays busy len cycles (len >= 2)
  //   M_DROP   : owner drops req, sampled k edges after grant
  //   M_TIMEOUT: owner never starts
  task automatic applyStimulus(input logic [3:0] mask, input int mode, input int k, input int len);
    int         w;
    int         g;
    int         f;
    int         b;
    int         r;
    int         d;
    int         e;
    int         pre;
    logic [3:0] oh;
    w     = rr_winner(mask, ptr_m);
    ptr_m = w;
    oh    = 4'b0001 << w;
    g     = cyc + 1;
    req   = mask;
    exp_q.push_back(make_rec("grant", g, oh, w, 1'b0, 1'b0));
    case (mode)
      M_NORMAL: begin
        f   = g + k - 1;
        b   = f + 1;
        r   = f + len;
        pre = b + LAT_TIMER + 1;
        exp_q.push_back(make_rec("busy_start", b, oh, w, 1'b1, 1'b0));
        if (pre <= r && (mask & ~oh) != 4'b0000)
          exp_q.push_back(make_rec("preempt", pre, 4'b0000, w, 1'b1, 1'b0));
        exp_q.push_back(make_rec("busy_end", r + 1, 4'b0000, w, 1'b0, 1'b0));
        tick_to(f);
        frame_n = 1'b0;
        tick_to(f + 1);
        irdy_n = 1'b0;
        tick_to(r - 1);
        frame_n = 1'b1;
        tick_to(r);
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        tick_to(r + 2);
      end
      M_DROP: begin
        d = g + k - 1;
        exp_q.push_back(make_rec("drop_turn", d + 1, 4'b0000, w, 1'b0, 1'b0));
        tick_to(d);
        req = mask & ~oh;
        tick_to(d + 2);
      end
      default: begin
        e = g + GNT_TO;
        exp_q.push_back(make_rec("timeout_pulse", e, 4'b0000, w, 1'b0, 1'b1));
        exp_q.push_back(make_rec("timeout_end", e + 1, 4'b0000, w, 1'b0, 1'b0));
        tick_to(e + 1);
      end
    endcase
  endtask

  initial begin
    reset_n = 1'b1;
    req     = 4'b0000;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_owner", 32'(owner), 32'h0);
    checkOutput("reset_owner_vld", 32'(owner_vld), 32'h0);
    checkOutput("reset_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
`ifdef PCI_ARB_PARK_EN
    checkOutput("idle_gnt_parked", 32'(gnt), 32'h8);
`else
    checkOutput("idle_gnt", 32'(gnt), 32'h0);
`endif

`ifndef PCI_ARB_PARK_EN
    $display("[TB] scoreboard scenarios start at cycle %0d", cyc);
    mon_en = 1'b1;
    // All four requesting: grants rotate 0,1,2,3,0.
    for (int n = 0; n < 5; n++) applyStimulus(4'b1111, M_NORMAL, 2, 4);
    // Unused grant expires, then master 2 is granted again.
    applyStimulus(4'b0100, M_TIMEOUT, 0, 0);
    applyStimulus(4'b0100, M_NORMAL, 2, 3);
    // Long transaction by master 1 with master 3 waiting: preemption,
    // then master 3 follows the turnaround.
    applyStimulus(4'b0001, M_NORMAL, 1, 2);
    applyStimulus(4'b1010, M_NORMAL, 1, 40);
    applyStimulus(4'b1000, M_NORMAL, 2, 3);
    // FRAME# on the expiry edge, req dropped on the expiry edge, and a
    // transaction ending exactly when the latency timer would fire.
    applyStimulus(4'b0010, M_NORMAL, GNT_TO, 3);
    applyStimulus(4'b0001, M_DROP, GNT_TO, 0);
    applyStimulus(4'b0110, M_NORMAL, 1, LAT_TIMER + 1);
    req = 4'b0000;
    tick();

    for (int n = 0; n < 40; n++) begin
      int         mode;
      int         gap;
      logic [3:0] m;
      m    = 4'($urandom_range(15, 1));
      mode = int'($urandom_range(3, 0));
      case (mode)
        0:       applyStimulus(m, M_NORMAL, int'($urandom_range(GNT_TO, 1)), int'($urandom_range(10, 2)));
        1:       applyStimulus(m, M_NORMAL, int'($urandom_range(GNT_TO, 1)),
                               int'($urandom_range(LAT_TIMER + 8, LAT_TIMER - 2)));
        2:       applyStimulus(m, M_DROP, int'($urandom_range(GNT_TO, 1)), 0);
        default: applyStimulus(m, M_TIMEOUT, 0, 0);
      endcase
      gap = int'($urandom_range(3, 0));
      if (gap != 0) begin
        req = 4'b0000;
        repeat (gap) tick();
      end
    end
    req = 4'b0000;
    repeat (6) tick();
    checkOutput("pending_events", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;
`endif

    // Asynchronous reset in the middle of a transaction.
    req = 4'b0100;
    tick();
    frame_n = 1'b0;
    tick();
    tick();
    checkOutput("busy_before_reset", 32'(owner_vld), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_gnt", 32'(gnt), 32'h0);
    checkOutput("async_reset_owner_vld", 32'(owner_vld), 32'h0);
    req     = 4'b0011;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    #3 reset_n = 1'b1;
    tick();
    checkOutput("post_reset_gnt", 32'(gnt), 32'h1);
    checkOutput("post_reset_owner", 32'(owner), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
